// File: rtl/mips_mc_core_pkg.sv
// rtl/mips_mc_core_pkg.sv - shared types, opcodes, FSM states and ALU controls for mips_mc_core
//
// Contents: u1/u32 scalar typedefs, opcode and funct constants, controller state enum,
// ALU-control enum, ALU operand-select enums and the R-type funct decoder.
package mips_mc_core_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
        S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_IMMLEX
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ZERO} alu_ctl_e;
    typedef enum logic {SRCA_PC, SRCA_REG} src_a_e;
    typedef enum logic [1:0] {SRCB_REG, SRCB_SIMM, SRCB_SIMM_SH2, SRCB_ZIMM} src_b_e;

    // Unknown funct codes produce zero; the destination register is still written.
    function automatic alu_ctl_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_core_if.sv
// rtl/mips_mc_core_if.sv - core <-> unified memory bus
//
// master (core):   drives iord, memwrite, irwrite, pc, aluout, writedata; receives instr, readdata
// slave  (memory): the opposite directions; the memory also owns the instruction register
interface mips_mc_core_if;
    import mips_mc_core_pkg::*;

    u32 instr;
    u32 readdata;
    u1  iord;
    u1  memwrite;
    u1  irwrite;
    u32 pc;
    u32 aluout;
    u32 writedata;

    modport master (input instr, readdata, output iord, memwrite, irwrite, pc, aluout, writedata);
    modport slave  (output instr, readdata, input iord, memwrite, irwrite, pc, aluout, writedata);
endinterface

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle controller FSM and ALU decode
//
// Ports: clk, reset (sync, active-high); op/funct from the external IR;
// Moore control outputs: iord, irwrite, memwrite, pcwrite, branch, jump, regwrite,
// reg_dst_rd, mem_to_reg, aluout_en, src_a, src_b, alu_ctl.
// Macro MIPS_IMM_LOGIC_EN: routes andi/ori through IMMLEX; otherwise they decode as nops.
module mips_mc_ctrl
    import mips_mc_core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output u1          iord,
    output u1          irwrite,
    output u1          memwrite,
    output u1          pcwrite,
    output u1          branch,
    output u1          jump,
    output u1          regwrite,
    output u1          reg_dst_rd,
    output u1          mem_to_reg,
    output u1          aluout_en,
    output src_a_e     src_a,
    output src_b_e     src_b,
    output alu_ctl_e   alu_ctl
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        regwrite   = 1'b0;
        reg_dst_rd = 1'b0;
        mem_to_reg = 1'b0;
        aluout_en  = 1'b0;
        src_a      = SRCA_REG;
        src_b      = SRCB_SIMM;
        alu_ctl    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here from the already-incremented pc.
                src_a     = SRCA_PC;
                src_b     = SRCB_SIMM_SH2;
                aluout_en = 1'b1;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MIPS_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_d = S_IMMLEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                aluout_en = 1'b1;
                state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                regwrite   = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTYPEEX: begin
                src_b     = SRCB_REG;
                alu_ctl   = funct_to_alu(funct);
                aluout_en = 1'b1;
                state_d   = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite   = 1'b1;
                reg_dst_rd = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                aluout_en = 1'b1;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                jump    = 1'b1;
                state_d = S_FETCH;
            end
            S_IMMLEX: begin
                src_b     = SRCB_ZIMM;
                alu_ctl   = (op == OP_ANDI) ? ALU_AND : ALU_OR;
                aluout_en = 1'b1;
                state_d   = S_ADDIWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multicycle MIPS-32 integer core (datapath, register file, controller)
//
// Ports: clk, reset (sync, active-high); bus (mips_mc_core_if.master) carrying instr,
// readdata, iord, memwrite, irwrite, pc, aluout, writedata.
// Parameter RESET_PC: pc value loaded on reset. Macro MIPS_IMM_LOGIC_EN enables andi/ori.
module mips_mc_core
    import mips_mc_core_pkg::*;
#(
    parameter u32 RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    mips_mc_core_if.master bus
);

    u1 c_iord, c_irwrite, c_memwrite, pcwrite, branch, jump;
    u1 regwrite, reg_dst_rd, mem_to_reg, aluout_en;
    src_a_e   src_a;
    src_b_e   src_b;
    alu_ctl_e alu_ctl;

    logic [4:0] rs, rt, rd, rf_wa;
    u32 signimm, zeroimm, src_a_val, src_b_val, alu_y, rf_wd;
    u1  rf_we;

    u32 pc_q, pc_d, a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    u32 rf_q [32];

    mips_mc_ctrl u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .op         (bus.instr[31:26]),
        .funct      (bus.instr[5:0]),
        .iord       (c_iord),
        .irwrite    (c_irwrite),
        .memwrite   (c_memwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .jump       (jump),
        .regwrite   (regwrite),
        .reg_dst_rd (reg_dst_rd),
        .mem_to_reg (mem_to_reg),
        .aluout_en  (aluout_en),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_ctl    (alu_ctl)
    );

    always_comb begin
        rs      = bus.instr[25:21];
        rt      = bus.instr[20:16];
        rd      = bus.instr[15:11];
        signimm = {{16{bus.instr[15]}}, bus.instr[15:0]};
        zeroimm = {16'h0000, bus.instr[15:0]};

        // $0 is never written, so its read is forced rather than relying on storage contents.
        a_d = (rs == 5'd0) ? 32'h0 : rf_q[rs];
        b_d = (rt == 5'd0) ? 32'h0 : rf_q[rt];

        src_a_val = (src_a == SRCA_PC) ? pc_q : a_q;
        case (src_b)
            SRCB_REG:      src_b_val = b_q;
            SRCB_SIMM:     src_b_val = signimm;
            SRCB_SIMM_SH2: src_b_val = {signimm[29:0], 2'b00};
            default:       src_b_val = zeroimm;
        endcase

        case (alu_ctl)
            ALU_ADD: alu_y = src_a_val + src_b_val;
            ALU_SUB: alu_y = src_a_val - src_b_val;
            ALU_AND: alu_y = src_a_val & src_b_val;
            ALU_OR:  alu_y = src_a_val | src_b_val;
            ALU_SLT: alu_y = {31'b0, $signed(src_a_val) < $signed(src_b_val)};
            default: alu_y = 32'h0;
        endcase
        aluout_d = aluout_en ? alu_y : aluout_q;

        pc_d = pc_q;
        if (pcwrite)                  pc_d = pc_q + 32'd4;
        if (branch && (a_q == b_q))   pc_d = aluout_q;
        if (jump)                     pc_d = {pc_q[31:28], bus.instr[25:0], 2'b00};

        // Reset abandons a writeback that is in flight.
        rf_wa = reg_dst_rd ? rd : rt;
        rf_wd = mem_to_reg ? bus.readdata : aluout_q;
        rf_we = regwrite && !reset && (rf_wa != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            aluout_q <= 32'h0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end

    // While reset is held the bus looks like FETCH, so no store escapes an abandoned MEMWR.
    assign bus.iord      = c_iord && !reset;
    assign bus.memwrite  = c_memwrite && !reset;
    assign bus.irwrite   = c_irwrite || reset;
    assign bus.pc        = pc_q;
    assign bus.aluout    = aluout_q;
    assign bus.writedata = b_q;

endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - self-checking bench for mips_mc_core against an instruction-level model
module tb_mips_mc_core;
    import mips_mc_core_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mips_mc_core_if bus();

    mips_mc_core #(.RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Unified memory with the instruction register; loaded through a bench port.
    logic [31:0] mem [256];
    logic [7:0]  maddr;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [31:0] ld_data = 32'h0;
    assign maddr = bus.iord ? bus.aluout[9:2] : bus.pc[9:2];

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.memwrite) mem[maddr] <= bus.writedata;
        if (bus.irwrite) bus.instr <= mem[maddr];
        bus.readdata <= mem[maddr];
    end

    int n_tests = 0;
    int n_fail = 0;
    bit aborted = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference model
    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [256];
    logic [31:0] m_pc;

    task automatic model_step(output int cyc, output bit st, output logic [31:0] st_a,
                              output logic [31:0] st_d, output bit wbv, output logic [31:0] wb);
        logic [31:0] ins, a, b, simm, zimm, pc4, npc, r, addr;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        ins = m_mem[m_pc[9:2]];
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        a = m_rf[rs]; b = m_rf[rt];
        simm = {{16{ins[15]}}, ins[15:0]};
        zimm = {16'h0, ins[15:0]};
        pc4 = m_pc + 32'd4; npc = pc4;
        st = 1'b0; st_a = 32'h0; st_d = 32'h0; wbv = 1'b0; wb = 32'h0; r = 32'h0; cyc = 2;
        case (op)
            6'h00: begin
                cyc = 4;
                case (ins[5:0])
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: r = 32'h0;
                endcase
                wbv = 1'b1; wb = r;
                if (rd != 5'd0) m_rf[rd] = r;
            end
            6'h23: begin
                cyc = 5; addr = a + simm;
                if (rt != 5'd0) m_rf[rt] = m_mem[addr[9:2]];
            end
            6'h2B: begin
                cyc = 4; addr = a + simm;
                st = 1'b1; st_a = addr; st_d = b;
                m_mem[addr[9:2]] = b;
            end
            6'h04: begin
                cyc = 3;
                if (a == b) npc = pc4 + (simm << 2);
            end
            6'h08: begin
                cyc = 4; r = a + simm; wbv = 1'b1; wb = r;
                if (rt != 5'd0) m_rf[rt] = r;
            end
            6'h02: begin
                cyc = 3; npc = {pc4[31:28], ins[25:0], 2'b00};
            end
`ifdef MIPS_IMM_LOGIC_EN
            6'h0C, 6'h0D: begin
                cyc = 4; r = (op == 6'h0C) ? (a & zimm) : (a | zimm);
                wbv = 1'b1; wb = r;
                if (rt != 5'd0) m_rf[rt] = r;
            end
`endif
            default: cyc = 2;
        endcase
        m_pc = npc;
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        ld_en = 1'b1; ld_addr = 8'(idx); ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
        m_mem[idx] = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_aluout", bus.aluout, 32'h0);
        check("rst_writedata", bus.writedata, 32'h0);
        check("rst_iord", 32'(bus.iord), 32'd0);
        check("rst_memwrite", 32'(bus.memwrite), 32'd0);
        check("rst_irwrite", 32'(bus.irwrite), 32'd1);
        reset = 1'b0;
        m_pc = 32'h0;
    endtask

    // Called at a negedge inside a FETCH cycle; runs until the model reaches end_pc.
    task automatic run_prog(input logic [31:0] end_pc);
        int cyc, exp_cyc, nst;
        bit st, wbv;
        logic [31:0] sa, sd, wb, last_alu, fpc;
        for (int n = 0; n < 200; n++) begin
            check("fetch_pc", bus.pc, m_pc);
            if (m_pc == end_pc) return;
            fpc = m_pc;
            model_step(exp_cyc, st, sa, sd, wbv, wb);
            cyc = 1; nst = 0; last_alu = 32'h0;
            while (1) begin
                @(negedge clk);
                if (bus.irwrite) break;
                cyc++;
                if (cyc == 2) check("pc_inc", bus.pc, fpc + 32'd4);
                last_alu = bus.aluout;
                if (bus.memwrite) begin
                    nst++;
                    check("st_iord", 32'(bus.iord), 32'd1);
                    check("st_addr", bus.aluout, sa);
                    check("st_data", bus.writedata, sd);
                end
                if (cyc > 8) begin
                    check("cycle_budget", 32'(cyc), 32'(exp_cyc));
                    aborted = 1'b1;
                    return;
                end
            end
            check("cpi", 32'(cyc), 32'(exp_cyc));
            check("n_store", 32'(nst), 32'(st));
            if (wbv) check("wb_val", last_alu, wb);
        end
        check("insn_budget", m_pc, end_pc);
        aborted = 1'b1;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    logic [31:0] prog [256];
    logic [5:0]  fn_tab [6];

    initial begin
        int found;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
        fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A; fn_tab[5] = 6'h27;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        @(negedge clk);

        // Directed program: addi, add, sw, lw, beq taken, sw, beq not taken, j, unknown, sw.
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
        prog[0] = 32'h20020005; prog[1] = 32'h00421820; prog[2] = 32'hac030054;
        prog[3] = 32'h8c040054; prog[4] = 32'h10420002; prog[7] = 32'hac040058;
        prog[8] = 32'h10430002; prog[9] = 32'h08000011; prog[17] = 32'hfc000000;
        prog[18] = 32'hac03005c;
        for (int i = 0; i < 256; i++) load_word(i, prog[i]);
        do_reset();
        run_prog(32'h48);

        // Reset during MEMWR must suppress the store and restart at RESET_PC.
        if (!aborted) begin
            found = 0;
            for (int k = 0; k < 8 && found == 0; k++) begin
                @(negedge clk);
                if (bus.memwrite) found = 1;
            end
            check("find_memwr", 32'(found), 32'd1);
            reset = 1'b1;
            #1;
            check("rst_mw_gate", 32'(bus.memwrite), 32'd0);
            check("rst_ir_force", 32'(bus.irwrite), 32'd1);
            @(negedge clk);
            check("rst2_pc", bus.pc, 32'h0);
            check("rst2_memwrite", 32'(bus.memwrite), 32'd0);
            check("rst2_iord", 32'(bus.iord), 32'd0);
            check("rst2_aluout", bus.aluout, 32'h0);
            check("rst2_no_store", mem[23], m_mem[23]);
        end

        // Random programs: prologue seeds $1..$7, random body, epilogue stores $1..$7.
        for (int run = 0; run < 4 && !aborted; run++) begin
            reset = 1'b1;
            for (int i = 0; i < 256; i++) prog[i] = 32'h0;
            for (int i = 128; i < 192; i++) prog[i] = $urandom;
            for (int i = 0; i < 7; i++)
                prog[i] = enc_i(6'h08, 5'd0, 5'(i + 1), 16'($urandom));
            for (int i = 7; i < 67; i++) begin
                logic [4:0] r1, r2, r3;
                int kind, off;
                r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
                r3 = 5'($urandom_range(0, 7));
                kind = int'($urandom_range(0, 9));
                case (kind)
                    0, 1: prog[i] = {6'h00, r1, r2, r3, 5'd0, fn_tab[$urandom_range(0, 5)]};
                    2: prog[i] = enc_i(6'h08, r1, r2, 16'($urandom));
                    3: prog[i] = enc_i(6'h23, 5'd0, r2, 16'(32'h200 + 4 * $urandom_range(0, 63)));
                    4: prog[i] = enc_i(6'h2B, 5'd0, r2, 16'(32'h200 + 4 * $urandom_range(0, 63)));
                    5, 6: begin
                        off = int'($urandom_range(0, 3));
                        if (off > 66 - i) off = 66 - i;
                        prog[i] = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'(off));
                    end
                    7: prog[i] = {6'h02, 26'($urandom_range(i + 1, 67))};
                    8: prog[i] = enc_i(($urandom_range(0, 1) == 0) ? 6'h0C : 6'h0D, r1, r2, 16'($urandom));
                    default: prog[i] = ($urandom_range(0, 1) == 0) ? (32'hfc000000 | 32'($urandom_range(0, 65535)))
                                                                   : enc_i(6'h0F, r1, r2, 16'($urandom));
                endcase
            end
            for (int r = 1; r < 8; r++)
                prog[66 + r] = enc_i(6'h2B, 5'd0, 5'(r), 16'(32'h300 + 4 * r));
            for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
            for (int i = 0; i < 256; i++) load_word(i, prog[i]);
            do_reset();
            run_prog(32'd74 * 32'd4);
            if (!aborted)
                for (int i = 128; i < 256; i++) check("dmem", mem[i], m_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
